i2c_config_seq: RTL
===================

Name: i2c_config_seq

Overview:
Power-up register-initialisation sequencer for the HDMI transmitter I2C link. Walks an external lookup table of 24-bit {slave address, sub address, data} write words. Issues each word to the I2C transaction engine with a go/done handshake and retries failed writes. Reports completion or failure to the rest of the overlay design and can be re-triggered at runtime, e.g. on hot-plug.

Parameters:
LUT_SIZE, 16, number of LUT entries written per configuration pass (1..256)
LUT_AW, 8, width of lut_addr
PWR_DELAY, 1000, clk cycles waited after reset release or restart before the first write
GAP_CYCLES, 32, idle clk cycles inserted between consecutive transactions
MAX_RETRY, 3, re-issues allowed per entry after ack failure

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
restart  input  1  single-cycle pulse; begin a new configuration pass
lut_addr  output  LUT_AW  index of the entry being fetched
lut_data  input  24  LUT word for lut_addr, valid the cycle after lut_addr changes
i2c_data  output  24  word presented to the transaction engine
i2c_go  output  1  single-cycle transaction request
i2c_done  input  1  single-cycle pulse from engine, transaction finished
i2c_ack_err  input  1  sampled with i2c_done; 1 = slave did not acknowledge
busy  output  1  pass in progress
config_done  output  1  level; last pass completed without error
config_err  output  1  level; last pass aborted after retries exhausted
err_index  output  LUT_AW  entry index that failed

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low. While reset is low: state=PWR_WAIT with the delay counter cleared; lut_addr=0, i2c_data=0, i2c_go=0, busy=1, config_done=0, config_err=0, err_index=0. When reset deasserts, a pass starts automatically.
- States and transitions:
  - PWR_WAIT: count PWR_DELAY cycles, then go to FETCH.
  - FETCH: lut_addr = entry index; wait 1 cycle for lut_data; go to ISSUE.
  - ISSUE: latch lut_data into i2c_data; pulse i2c_go for exactly 1 cycle; go to WAIT_DONE.
  - WAIT_DONE: hold i2c_data stable; ignore all inputs except i2c_done.
    - On i2c_done with ack_err=0: go to GAP.
    - On i2c_done with ack_err=1: if retry count < MAX_RETRY, increment it and go to GAP, then re-ISSUE the same entry. Otherwise go to FAIL.
  - GAP: wait GAP_CYCLES cycles.
    - If retrying: go to ISSUE.
    - If index == LUT_SIZE-1: go to DONE.
    - Otherwise: index+1, clear retry count, go to FETCH.
  - DONE: busy=0, config_done=1; wait for restart.
  - FAIL: busy=0, config_err=1, err_index=failing index; wait for restart.
- Single-entry LUT (LUT_SIZE=1): the pass ends after one successful write.
- Retries: total issues per entry ≤ MAX_RETRY+1. The retry count resets to 0 on each new entry. MAX_RETRY=0 means fail on the first NACK.
- restart:
  - In DONE/FAIL: clear config_done, config_err and the retry count; index=0; go to PWR_WAIT.
  - While busy: ignored. The sequencer never aborts a transaction in flight.
- i2c_done arriving outside WAIT_DONE is ignored.
- No watchdog: the sequencer waits indefinitely for i2c_done.
- Counters are saturating-safe. The delay and gap counters are sized to hold their parameter, and LUT_SIZE must be ≤ 2^LUT_AW.
- i2c_go is never asserted while busy=0. At most one go is outstanding.
- config_done and config_err are never 1 simultaneously.
- Reset asserted mid-pass: immediate return to reset values. The pass restarts from entry 0 after reset deasserts.

Test Plan:
1. LUT_SIZE=4, engine returns done 50 cycles after each go with ack_err=0 -> after PWR_DELAY: 4 go pulses carrying LUT words 0..3 in order, each separated by ≥GAP_CYCLES; then config_done=1, busy=0, config_err=0.
2. Entry 2 NACKs twice, then ACKs (MAX_RETRY=3) -> entry 2 issued 3 times with identical i2c_data; the pass finishes with config_done=1.
3. Entry 1 always NACKs -> exactly 4 issues of entry 1; config_err=1, err_index=1, no go for entry 2.
4. From the FAIL state of test 3, pulse restart with the bench now ACKing -> flags clear; PWR_DELAY wait; full pass from entry 0; config_done=1.
5. Assert reset low during the WAIT_DONE of entry 2, hold 5 cycles -> outputs at reset values immediately; after release, the first go carries entry 0.
6. Spurious i2c_done pulses in PWR_WAIT/GAP and restart pulses while busy -> no state change, no extra go; go count equals LUT_SIZE.

Source files
------------

// File: rtl/i2c_config_seq.sv
// i2c_config_seq: power-up I2C register-initialisation sequencer driven by an external LUT
// Ports: clk/reset (async active-low), restart pulse; lut_addr/lut_data LUT fetch;
// i2c_data/i2c_go/i2c_done/i2c_ack_err engine handshake; busy/config_done/config_err/err_index status.
module i2c_config_seq #(
    parameter int LUT_SIZE   = 16,
    parameter int LUT_AW     = 8,
    parameter int PWR_DELAY  = 1000,
    parameter int GAP_CYCLES = 32,
    parameter int MAX_RETRY  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [23:0]       lut_data,
    output logic [23:0]       i2c_data,
    output logic              i2c_go,
    input  logic              i2c_done,
    input  logic              i2c_ack_err,
    output logic              busy,
    output logic              config_done,
    output logic              config_err,
    output logic [LUT_AW-1:0] err_index
);
    localparam int CMAX = PWR_DELAY > GAP_CYCLES ? PWR_DELAY : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1) < 1 ? 1 : $clog2(CMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 1) < 1 ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {PWR_WAIT, FETCH, ISSUE, WAIT_DONE, GAP, DONE, FAIL} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LUT_AW-1:0] idx_q, idx_d, err_index_q, err_index_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              retrying_q, retrying_d;
    logic [23:0]       data_q, data_d;
    logic              go_q, go_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              cnt_last;

    // one shared counter times both the power-up wait and the inter-transaction gap
    assign cnt_last = int'(cnt_q) + 1 >= (state_q == PWR_WAIT ? PWR_DELAY : GAP_CYCLES);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        retrying_d  = retrying_q;
        data_d      = data_q;
        go_d        = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        err_index_d = err_index_q;
        case (state_q)
            PWR_WAIT: begin
                state_d = cnt_last ? FETCH : PWR_WAIT;
                cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
            end
            FETCH: state_d = ISSUE;
            ISSUE: begin
                data_d  = lut_data;
                go_d    = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i2c_done) begin
                    cnt_d = '0;
                    if (!i2c_ack_err) begin
                        state_d    = GAP;
                        retrying_d = 1'b0;
                    end else if (int'(retry_q) < MAX_RETRY) begin
                        state_d    = GAP;
                        retry_d    = retry_q + 1'b1;
                        retrying_d = 1'b1;
                    end else begin
                        state_d     = FAIL;
                        err_d       = 1'b1;
                        err_index_d = idx_q;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    if (retrying_q) begin
                        state_d    = ISSUE;
                        retrying_d = 1'b0;
                    end else if (int'(idx_q) == LUT_SIZE - 1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        idx_d   = idx_q + 1'b1;
                        retry_d = '0;
                    end
                end
            end
            DONE, FAIL: begin
                if (restart) begin
                    state_d    = PWR_WAIT;
                    cnt_d      = '0;
                    idx_d      = '0;
                    retry_d    = '0;
                    retrying_d = 1'b0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    assign busy_d = !(state_d == DONE || state_d == FAIL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            retrying_q  <= 1'b0;
            data_q      <= '0;
            go_q        <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            retrying_q  <= retrying_d;
            data_q      <= data_d;
            go_q        <= go_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_index_q <= err_index_d;
        end
    end

    assign lut_addr    = idx_q;
    assign i2c_data    = data_q;
    assign i2c_go      = go_q;
    assign busy        = busy_q;
    assign config_done = done_q;
    assign config_err  = err_q;
    assign err_index   = err_index_q;
endmodule
